// File: rtl/nmr_bstrm_pulse_meas_if.sv
// Run-length record stream of the bitstream pulse decoder.
// The master presents {data, pls_pol}; a record moves on dvalid && dready.
interface nmr_bstrm_pulse_meas_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] data;
    logic                  pls_pol;
    logic                  dvalid;
    logic                  dready;

    modport master (output data, output pls_pol, output dvalid, input dready);
    modport slave  (input data, input pls_pol, input dvalid, output dready);
endinterface

// File: rtl/nmr_bstrm_pulse_meas.sv
// Bitstream pulse-length decoder: measures each run of constant level on i_in in
// clock cycles and emits one {length, polarity} record per run on a valid/ready stream.
module nmr_bstrm_pulse_meas #(
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [CNT_WIDTH-1:0] i_num_pls,
    input  logic                 i_in,
    nmr_bstrm_pulse_meas_if.master m_rec,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_ovf,
    output logic                 o_sat
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_s_d;
    logic                    w_s;
    logic                    w_edge;
    logic                    w_emit;
    logic [CNT_WIDTH-1:0]    r_num_pls;
    logic [CNT_WIDTH-1:0]    r_idx;
    logic [CNT_WIDTH-1:0]    w_idx_inc;
    logic [DATA_WIDTH-1:0]   r_run_cnt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_pol;
    logic                    r_dvalid;
    logic                    r_ovf;
    logic                    r_sat;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_edge    = (w_s != r_s_d);
    assign w_idx_inc = r_idx + CNT_WIDTH'(1);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (i_stop)      w_state_nxt = ST_FIN;
                else if (w_edge) w_state_nxt = ST_MEAS;
            end
            ST_MEAS: begin
                if (i_stop) begin
                    w_state_nxt = ST_FIN;
                end else if (w_edge) begin
                    w_emit = 1'b1;
                    if ((r_num_pls != '0) && (w_idx_inc == r_num_pls)) w_state_nxt = ST_FIN;
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: synchronous reset clears every register including the synchronizer,
    // so no stale level can masquerade as an edge after reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync    <= '0;
            r_s_d     <= 1'b0;
            r_num_pls <= '0;
            r_idx     <= '0;
            r_run_cnt <= '0;
            r_data    <= '0;
            r_pol     <= 1'b0;
            r_dvalid  <= 1'b0;
            r_ovf     <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_sync[0] <= i_in;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            r_s_d <= w_s;

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_num_pls <= i_num_pls;
                        r_idx     <= '0;
                        r_ovf     <= 1'b0;
                        r_sat     <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (!i_stop && w_edge) r_run_cnt <= DATA_WIDTH'(1);
                end
                ST_MEAS: begin
                    if (!i_stop) begin
                        if (w_edge) begin
                            r_run_cnt <= DATA_WIDTH'(1);
                            r_idx     <= w_idx_inc;
                        end else if (r_run_cnt == '1) begin
                            r_sat <= 1'b1;
                        end else begin
                            r_run_cnt <= r_run_cnt + DATA_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase

            // A full, stalled output keeps its record; the newcomer is lost and flagged.
            if (w_emit) begin
                if (!r_dvalid || m_rec.dready) begin
                    r_data   <= r_run_cnt;
                    r_pol    <= r_s_d;
                    r_dvalid <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (r_dvalid && m_rec.dready) begin
                r_dvalid <= 1'b0;
            end
        end
    end

    assign m_rec.data    = r_data;
    assign m_rec.pls_pol = r_pol;
    assign m_rec.dvalid  = r_dvalid;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_FIN);
    assign o_ovf         = r_ovf;
    assign o_sat         = r_sat;

endmodule

// File: tb/tb_nmr_bstrm_pulse_meas.sv
// Self-checking bench for nmr_bstrm_pulse_meas: scoreboarded records from a 32-bit
// instance plus a 4-bit instance in lockstep for saturation.
module tb_nmr_bstrm_pulse_meas;

    localparam int SYNC = 2;

    typedef struct packed {
        logic [31:0] len;
        logic        pol;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] num_pls;
    logic        in_bit;
    logic        busy, done, ovf, sat;
    logic        busy4, done4, ovf4, sat4;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    rec_t sb[$];
    bit   seen;

    nmr_bstrm_pulse_meas_if #(.DATA_WIDTH(32)) rec_if ();
    nmr_bstrm_pulse_meas_if #(.DATA_WIDTH(4))  rec4_if ();

    assign rec4_if.dready = 1'b1;

    nmr_bstrm_pulse_meas #(.DATA_WIDTH(32), .CNT_WIDTH(16), .SYNC_STAGES(SYNC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_num_pls(num_pls), .i_in(in_bit), .m_rec(rec_if),
        .o_busy(busy), .o_done(done), .o_ovf(ovf), .o_sat(sat)
    );

    nmr_bstrm_pulse_meas #(.DATA_WIDTH(4), .CNT_WIDTH(16), .SYNC_STAGES(SYNC)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .i_num_pls(num_pls), .i_in(in_bit), .m_rec(rec4_if),
        .o_busy(busy4), .o_done(done4), .o_ovf(ovf4), .o_sat(sat4)
    );

    always #5 clk = ~clk;

    // Accepted records are compared against the scoreboard on the falling edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (rst_n === 1'b1 && rec_if.dvalid === 1'b1 && rec_if.dready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_record: got data=%0d pol=%0d, required no record",
                         rec_if.data, rec_if.pls_pol);
            end else begin
                rec_t e;
                e = sb.pop_front();
                if (rec_if.data !== e.len || rec_if.pls_pol !== e.pol) begin
                    n_fail++;
                    $display("FAIL record: got data=%0d pol=%0d, required data=%0d pol=%0d",
                             rec_if.data, rec_if.pls_pol, e.len, e.pol);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int len, input logic pol);
        sb.push_back(rec_t'{len: 32'(len), pol: pol});
    endtask

    task automatic drive_run(input logic lvl, input int len);
        in_bit = lvl;
        repeat (len) step();
    endtask

    task automatic pulse_start(input logic [15:0] n);
        num_pls = n;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic idle_low();
        in_bit = 1'b0;
        repeat (4) step();
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL done_timeout: got no DONE in %0d cycles, required DONE", budget);
        end
    endtask

    task automatic drain(input string name);
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: got %0d records outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; num_pls = '0; in_bit = 1'b0;
        rec_if.dready = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({busy, done, ovf, sat, rec_if.dvalid, rec_if.pls_pol} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {busy, done, ovf, sat, rec_if.dvalid, rec_if.pls_pol});
        end
        n_checks++;
        if (rec_if.data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %0d, required 0", rec_if.data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        rec_if.dready = 1'b1;
        idle_low();
        push(5, 1'b1); push(7, 1'b0); push(2, 1'b1);
        pulse_start(16'd3);
        drive_run(1'b1, 5);
        drive_run(1'b0, 7);
        drive_run(1'b1, 2);
        in_bit = 1'b0;
        wait_done(20, seen);
        n_checks++;
        if (rec_if.dvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_final_valid: got dvalid=%b at DONE, required 1", rec_if.dvalid);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after_done: got busy=%b done=%b, required 0 0", busy, done);
        end
        drain("basic");
    endtask

    task automatic test_overflow();
        rec_if.dready = 1'b0;
        idle_low();
        push(4, 1'b1);
        pulse_start(16'd2);
        drive_run(1'b1, 4);
        drive_run(1'b0, 6);
        in_bit = 1'b1;
        wait_done(20, seen);
        n_checks++;
        if (ovf !== 1'b1 || rec_if.dvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: got ovf=%b dvalid=%b, required 1 1", ovf, rec_if.dvalid);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (rec_if.data !== 32'd4 || rec_if.pls_pol !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_held: got data=%0d pol=%b, required 4 1", rec_if.data, rec_if.pls_pol);
        end
        step();
        rec_if.dready = 1'b1;
        drain("ovf_held");
        push(3, 1'b0);
        pulse_start(16'd1);
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got ovf=%b after START, required 0", ovf);
        end
        drive_run(1'b0, 3);
        in_bit = 1'b1;
        wait_done(20, seen);
        drain("ovf_rerun");
    endtask

    task automatic test_saturation();
        idle_low();
        push(20, 1'b1);
        pulse_start(16'd1);
        drive_run(1'b1, 20);
        in_bit = 1'b0;
        wait_done(20, seen);
        n_checks++;
        if (rec4_if.dvalid !== 1'b1 || rec4_if.data !== 4'd15 || done4 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_data: got dvalid=%b data=%0d done=%b, required 1 15 1",
                     rec4_if.dvalid, rec4_if.data, done4);
        end
        n_checks++;
        if (sat4 !== 1'b1 || sat !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_flag: got sat4=%b sat32=%b, required 1 0", sat4, sat);
        end
        drain("sat");
    endtask

    task automatic test_stop_free_run();
        int d0;
        idle_low();
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) push(3, (i % 2 == 0));
        pulse_start(16'd0);
        for (int i = 0; i < 5; i++) drive_run((i % 2 == 0), 3);
        in_bit = 1'b0;
        repeat (4) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (6) step();
        n_checks++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_done: got %0d DONE pulses busy=%b, required 1 0", done_cnt - d0, busy);
        end
        drain("stop");
    endtask

    task automatic test_reset_mid();
        rec_if.dready = 1'b0;
        idle_low();
        pulse_start(16'd0);
        drive_run(1'b1, 3);
        drive_run(1'b0, 3);
        in_bit = 1'b1;
        repeat (4) step();
        n_checks++;
        if (rec_if.dvalid !== 1'b1 || ovf !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: got dvalid=%b ovf=%b busy=%b, required 1 1 1",
                     rec_if.dvalid, ovf, busy);
        end
        rst_n = 1'b0;
        step();
        n_checks++;
        if ({busy, done, ovf, sat, rec_if.dvalid, rec_if.pls_pol} !== 6'b0 || rec_if.data !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got flags=%b data=%0d, required 000000 0",
                     {busy, done, ovf, sat, rec_if.dvalid, rec_if.pls_pol}, rec_if.data);
        end
        rst_n = 1'b1;
        rec_if.dready = 1'b1;
        idle_low();
        push(3, 1'b1); push(3, 1'b0);
        pulse_start(16'd2);
        drive_run(1'b1, 3);
        in_bit  = 1'b0;
        num_pls = 16'd1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busy: got busy=%b, required 1", busy);
        end
        repeat (2) step();
        in_bit = 1'b1;
        wait_done(20, seen);
        drain("start_ignored");
    endtask

    task automatic test_edge_stop();
        rec_if.dready = 1'b1;
        idle_low();
        pulse_start(16'd0);
        drive_run(1'b1, 5);
        in_bit = 1'b0;
        repeat (SYNC) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++;
        if (done !== 1'b1 || rec_if.dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_stop: got done=%b dvalid=%b, required 1 0", done, rec_if.dvalid);
        end
        drain("edge_stop");
    endtask

    task automatic test_back_to_back();
        int d0;
        idle_low();
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) push(1, (i % 2 == 0));
        pulse_start(16'd6);
        for (int i = 0; i < 10; i++) begin
            in_bit = ~in_bit;
            step();
        end
        repeat (10) step();
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL toggle_done: got %0d DONE pulses, required 1", done_cnt - d0);
        end
        drain("toggle");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_saturation();
        test_stop_free_run();
        test_reset_mid();
        test_edge_stop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
